pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard and pipeline-sequencing controller for the 5-stage RV32IM core (IF, ID, EXE, MEM, WB).
- Generates per-stage hold and flush controls and the PC redirect.
- Covers load-use hazards that operand forwarding cannot resolve, multi-cycle mul/div, data-bus wait states, taken jumps/branches and traps.
- Sits beside the forwarding unit; drives the pipeline registers and the PC register.

Parameters:
- FLUSH_CYCLES, 1: extra IF/ID flush cycles after any redirect, covering fetch latency; legal range 0-3.
- STALL_CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_rs1_addr_i  in  5  ID rs1 address
- id_rs1_re_i  in  1  ID reads rs1
- id_rs2_addr_i  in  5  ID rs2 address
- id_rs2_re_i  in  1  ID reads rs2
- exe_rdaddr_i  in  5  EXE rd address
- exe_rdwe_i  in  1  EXE writes rd
- exe_load_i  in  1  EXE instruction is a load
- exe_md_start_i  in  1  EXE holds a multi-cycle mul/div
- md_done_i  in  1  mul/div result valid this cycle
- exe_jump_i  in  1  EXE jump/branch taken
- exe_jump_addr_i  in  `XLEN  jump target
- mem_req_i  in  1  MEM stage bus request
- mem_ready_i  in  1  data bus ready
- trap_req_i  in  1  trap request from CSR unit; held until acked
- trap_addr_i  in  `XLEN  trap vector
- trap_ack_o  out  1  trap accepted this cycle
- hold_pc_o, hold_ifid_o, hold_idexe_o, hold_exemem_o  out  1 each  freeze register
- flush_ifid_o, flush_idexe_o, flush_exemem_o, flush_memwb_o  out  1 each  load bubble; flush beats hold in the same register
- redirect_o  out  1  load PC from redirect_addr_o
- redirect_addr_o  out  `XLEN  new PC
- md_busy_o  out  1  mul/div in progress
- md_kill_o  out  1  abort mul/div

Behaviour:
- States: RUN, MD_WAIT, MEM_WAIT, FLUSH. A 2-bit counter fcnt is used in FLUSH.
- Reset: state=RUN, fcnt=0. While rst is high, all outputs are 0 and redirect_addr_o=0.
- Outputs are combinational from state and inputs; state and fcnt update on clk.
- lu (load-use) = exe_load_i & exe_rdwe_i & (exe_rdaddr_i!=0) & ((id_rs1_re_i & id_rs1_addr_i==exe_rdaddr_i) | (id_rs2_re_i & id_rs2_addr_i==exe_rdaddr_i)).
- "Redirect" means: if FLUSH_CYCLES>0 go to FLUSH with fcnt=FLUSH_CYCLES-1, otherwise go to RUN.
- RUN, first matching condition wins:
  1. trap_req_i: trap_ack_o, redirect_o, redirect_addr_o=trap_addr_i; all four flushes; md_kill_o if exe_md_start_i; then redirect.
  2. mem_req_i & !mem_ready_i: hold pc/ifid/idexe/exemem; flush_memwb_o; go to MEM_WAIT.
  3. exe_md_start_i & !md_done_i: hold pc/ifid/idexe; flush_exemem_o; md_busy_o; go to MD_WAIT.
  4. exe_jump_i: redirect_o with exe_jump_addr_i; flush ifid/idexe; then redirect.
  5. lu: hold pc/ifid; flush_idexe_o (one bubble); stay in RUN.
- MEM_WAIT:
  - Same outputs as RUN rule 2 while !mem_ready_i.
  - When mem_ready_i: no holds, go to RUN.
  - trap_req_i is not acked here.
- MD_WAIT:
  - trap_req_i: as RUN rule 1 plus md_kill_o.
  - Else while !md_done_i: as RUN rule 3.
  - When md_done_i: no holds, md_busy_o=0, go to RUN.
- FLUSH:
  - flush_ifid_o=1 every cycle.
  - trap_req_i: as RUN rule 1; fcnt reloads.
  - Else mem_req_i & !mem_ready_i: RUN rule 2 outputs; fcnt frozen; stay in FLUSH.
  - Else if fcnt==0 go to RUN, otherwise decrement fcnt.
  - Jump and load-use cannot occur here, because EXE holds a bubble.
- Same-cycle mem_ready_i with trap: the trap wins only in RUN, MD_WAIT and FLUSH.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, adds outputs stall_cycles_o and flush_cycles_o, each STALL_CNT_W wide.
  - stall_cycles_o increments on every cycle with hold_pc_o=1.
  - flush_cycles_o increments on every cycle with flush_ifid_o=1.
  - Both wrap at all-ones to 0 and reset to 0.
- When undefined, neither port nor counter exists.

Test Plan:
- Load x5 in EXE, ID reads rs2=x5 -> one cycle of hold_pc/hold_ifid/flush_idexe. Same case with rd=x0 -> no stall.
- exe_md_start_i with md_done_i arriving 33 cycles later -> md_busy_o high for 33 cycles, then released on the done cycle; state returns to RUN.
- exe_jump_i to 0x80 with FLUSH_CYCLES=1 -> cycle 0: redirect_o, addr 0x80, flush ifid/idexe; cycle 1: flush_ifid_o only; cycle 2: normal.
- trap_req_i during MD_WAIT, vector 0x100 -> trap_ack_o, md_kill_o, all flushes, redirect to 0x100 in the same cycle.
- trap_req_i held during a 3-cycle MEM_WAIT -> no ack for 3 cycles; ack on the first cycle after the return to RUN.
- With PIPE_CTRL_PERF_EN: a 5-cycle mem wait followed by one jump -> stall_cycles_o=5, flush_cycles_o=2.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the RV32IM pipeline and its hazard/sequencing controller.
// Latency: none (wires only). Backpressure: holds/flushes are the backpressure into the pipeline.
// master = pipeline/datapath side, slave = pipeline_ctrl.
`ifndef XLEN
`define XLEN 32
`endif

interface pipeline_ctrl_if;
    logic [4:0]       id_rs1_addr_i;
    logic             id_rs1_re_i;
    logic [4:0]       id_rs2_addr_i;
    logic             id_rs2_re_i;
    logic [4:0]       exe_rdaddr_i;
    logic             exe_rdwe_i;
    logic             exe_load_i;
    logic             exe_md_start_i;
    logic             md_done_i;
    logic             exe_jump_i;
    logic [`XLEN-1:0] exe_jump_addr_i;
    logic             mem_req_i;
    logic             mem_ready_i;
    logic             trap_req_i;
    logic [`XLEN-1:0] trap_addr_i;
    logic             trap_ack_o;
    logic             hold_pc_o;
    logic             hold_ifid_o;
    logic             hold_idexe_o;
    logic             hold_exemem_o;
    logic             flush_ifid_o;
    logic             flush_idexe_o;
    logic             flush_exemem_o;
    logic             flush_memwb_o;
    logic             redirect_o;
    logic [`XLEN-1:0] redirect_addr_o;
    logic             md_busy_o;
    logic             md_kill_o;

    modport master (
        output id_rs1_addr_i, id_rs1_re_i, id_rs2_addr_i, id_rs2_re_i,
               exe_rdaddr_i, exe_rdwe_i, exe_load_i, exe_md_start_i, md_done_i,
               exe_jump_i, exe_jump_addr_i, mem_req_i, mem_ready_i,
               trap_req_i, trap_addr_i,
        input  trap_ack_o, hold_pc_o, hold_ifid_o, hold_idexe_o, hold_exemem_o,
               flush_ifid_o, flush_idexe_o, flush_exemem_o, flush_memwb_o,
               redirect_o, redirect_addr_o, md_busy_o, md_kill_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs1_re_i, id_rs2_addr_i, id_rs2_re_i,
               exe_rdaddr_i, exe_rdwe_i, exe_load_i, exe_md_start_i, md_done_i,
               exe_jump_i, exe_jump_addr_i, mem_req_i, mem_ready_i,
               trap_req_i, trap_addr_i,
        output trap_ack_o, hold_pc_o, hold_ifid_o, hold_idexe_o, hold_exemem_o,
               flush_ifid_o, flush_idexe_o, flush_exemem_o, flush_memwb_o,
               redirect_o, redirect_addr_o, md_busy_o, md_kill_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller (load-use, mul/div, bus wait, jump, trap); perf counters under PIPE_CTRL_PERF_EN.
// Latency: controls are combinational from state and inputs; state changes on the next clk.
// Backpressure: a bus wait freezes PC..EXE/MEM, mul/div freezes PC..ID/EXE; traps are not acked during a bus wait.
`ifndef XLEN
`define XLEN 32
`endif

module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipeline_ctrl_if.slave     ctrl
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles_o,
    output logic [STALL_CNT_W-1:0] flush_cycles_o
`endif
);

    typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT, FLUSH} state_t;

    localparam logic [1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 0) ? 2'(FLUSH_CYCLES - 1) : 2'd0;

    state_t           state, state_nxt;
    logic [1:0]       fcnt, fcnt_nxt;
    logic             lu, mem_stall;
    logic             do_trap, do_mem, do_md, do_jump, do_lu;
    logic             trap_ack, hold_pc, hold_ifid, hold_idexe, hold_exemem;
    logic             flush_ifid, flush_idexe, flush_exemem, flush_memwb;
    logic             redirect, md_busy, md_kill;
    logic [`XLEN-1:0] redirect_addr;

    assign lu = ctrl.exe_load_i & ctrl.exe_rdwe_i & (ctrl.exe_rdaddr_i != 5'd0) &
                ((ctrl.id_rs1_re_i & (ctrl.id_rs1_addr_i == ctrl.exe_rdaddr_i)) |
                 (ctrl.id_rs2_re_i & (ctrl.id_rs2_addr_i == ctrl.exe_rdaddr_i)));
    assign mem_stall = ctrl.mem_req_i & ~ctrl.mem_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fcnt_nxt      = fcnt;
        do_trap       = 1'b0;
        do_mem        = 1'b0;
        do_md         = 1'b0;
        do_jump       = 1'b0;
        do_lu         = 1'b0;
        trap_ack      = 1'b0;
        hold_pc       = 1'b0;
        hold_ifid     = 1'b0;
        hold_idexe    = 1'b0;
        hold_exemem   = 1'b0;
        flush_ifid    = 1'b0;
        flush_idexe   = 1'b0;
        flush_exemem  = 1'b0;
        flush_memwb   = 1'b0;
        redirect      = 1'b0;
        md_busy       = 1'b0;
        md_kill       = 1'b0;
        redirect_addr = '0;

        // Pick one action per state first, then expand the action into controls.
        case (state)
            RUN: begin
                if (ctrl.trap_req_i)                                 do_trap = 1'b1;
                else if (mem_stall)                                  do_mem  = 1'b1;
                else if (ctrl.exe_md_start_i && !ctrl.md_done_i)     do_md   = 1'b1;
                else if (ctrl.exe_jump_i)                            do_jump = 1'b1;
                else if (lu)                                         do_lu   = 1'b1;
            end
            MEM_WAIT: begin
                if (!ctrl.mem_ready_i) do_mem = 1'b1;
                else                   state_nxt = RUN;
            end
            MD_WAIT: begin
                if (ctrl.trap_req_i) begin
                    do_trap = 1'b1;
                    md_kill = 1'b1;
                end else if (!ctrl.md_done_i) begin
                    do_md = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                flush_ifid = 1'b1;
                if (ctrl.trap_req_i)  do_trap = 1'b1;
                else if (mem_stall)   do_mem  = 1'b1;
                else if (fcnt == 2'd0) state_nxt = RUN;
                else                  fcnt_nxt = fcnt - 2'd1;
            end
            default: state_nxt = RUN;
        endcase

        if (do_mem) begin
            {hold_pc, hold_ifid, hold_idexe, hold_exemem} = 4'hf;
            flush_memwb = 1'b1;
            if (state != FLUSH) state_nxt = MEM_WAIT;
        end
        if (do_md) begin
            {hold_pc, hold_ifid, hold_idexe} = 3'h7;
            flush_exemem = 1'b1;
            md_busy      = 1'b1;
            state_nxt    = MD_WAIT;
        end
        if (do_lu) begin
            hold_pc     = 1'b1;
            hold_ifid   = 1'b1;
            flush_idexe = 1'b1;
        end
        if (do_trap || do_jump) begin
            redirect      = 1'b1;
            redirect_addr = do_trap ? ctrl.trap_addr_i : ctrl.exe_jump_addr_i;
            flush_ifid    = 1'b1;
            flush_idexe   = 1'b1;
            if (FLUSH_CYCLES > 0) begin
                state_nxt = FLUSH;
                fcnt_nxt  = FLUSH_RELOAD;
            end else begin
                state_nxt = RUN;
            end
        end
        if (do_trap) begin
            trap_ack     = 1'b1;
            flush_exemem = 1'b1;
            flush_memwb  = 1'b1;
            md_kill      = md_kill | ctrl.exe_md_start_i;
        end
    end

    assign ctrl.trap_ack_o      = trap_ack     & ~rst;
    assign ctrl.hold_pc_o       = hold_pc      & ~rst;
    assign ctrl.hold_ifid_o     = hold_ifid    & ~rst;
    assign ctrl.hold_idexe_o    = hold_idexe   & ~rst;
    assign ctrl.hold_exemem_o   = hold_exemem  & ~rst;
    assign ctrl.flush_ifid_o    = flush_ifid   & ~rst;
    assign ctrl.flush_idexe_o   = flush_idexe  & ~rst;
    assign ctrl.flush_exemem_o  = flush_exemem & ~rst;
    assign ctrl.flush_memwb_o   = flush_memwb  & ~rst;
    assign ctrl.redirect_o      = redirect     & ~rst;
    assign ctrl.md_busy_o       = md_busy      & ~rst;
    assign ctrl.md_kill_o       = md_kill      & ~rst;
    assign ctrl.redirect_addr_o = rst ? '0 : redirect_addr;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_o <= '0;
            flush_cycles_o <= '0;
        end else begin
            if (ctrl.hold_pc_o)    stall_cycles_o <= stall_cycles_o + 1'b1;
            if (ctrl.flush_ifid_o) flush_cycles_o <= flush_cycles_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected control vectors are queued as stimulus is driven
// and popped/compared mid-cycle against the DUT outputs.
module tb_pipeline_ctrl;

    localparam logic [11:0] TA   = 12'h800;
    localparam logic [11:0] HPC  = 12'h400;
    localparam logic [11:0] HIF  = 12'h200;
    localparam logic [11:0] HIDX = 12'h100;
    localparam logic [11:0] HEXM = 12'h080;
    localparam logic [11:0] FIF  = 12'h040;
    localparam logic [11:0] FIDX = 12'h020;
    localparam logic [11:0] FEXM = 12'h010;
    localparam logic [11:0] FMWB = 12'h008;
    localparam logic [11:0] RED  = 12'h004;
    localparam logic [11:0] MDB  = 12'h002;
    localparam logic [11:0] MDK  = 12'h001;

    localparam logic [11:0] LU   = HPC | HIF | FIDX;
    localparam logic [11:0] MEMW = HPC | HIF | HIDX | HEXM | FMWB;
    localparam logic [11:0] MDW  = HPC | HIF | HIDX | FEXM | MDB;
    localparam logic [11:0] JMP  = RED | FIF | FIDX;
    localparam logic [11:0] TRAP = TA | RED | FIF | FIDX | FEXM | FMWB;
    localparam logic [11:0] FLS  = FIF;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [11:0] sb_ctl[$];
    logic [31:0] sb_addr[$];
    string       sb_tag[$];

    pipeline_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    pipeline_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.slave)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_cycles_o (flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    logic [11:0] got_ctl;
    assign got_ctl = {bus.trap_ack_o, bus.hold_pc_o, bus.hold_ifid_o, bus.hold_idexe_o,
                      bus.hold_exemem_o, bus.flush_ifid_o, bus.flush_idexe_o,
                      bus.flush_exemem_o, bus.flush_memwb_o, bus.redirect_o,
                      bus.md_busy_o, bus.md_kill_o};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        bus.id_rs1_addr_i   = 5'd0;
        bus.id_rs1_re_i     = 1'b0;
        bus.id_rs2_addr_i   = 5'd0;
        bus.id_rs2_re_i     = 1'b0;
        bus.exe_rdaddr_i    = 5'd0;
        bus.exe_rdwe_i      = 1'b0;
        bus.exe_load_i      = 1'b0;
        bus.exe_md_start_i  = 1'b0;
        bus.md_done_i       = 1'b0;
        bus.exe_jump_i      = 1'b0;
        bus.exe_jump_addr_i = 32'h0;
        bus.mem_req_i       = 1'b0;
        bus.mem_ready_i     = 1'b0;
        bus.trap_req_i      = 1'b0;
        bus.trap_addr_i     = 32'h0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic load,
                          input logic [4:0] rs1, input logic re1,
                          input logic [4:0] rs2, input logic re2);
        bus.exe_rdaddr_i  = rd;
        bus.exe_rdwe_i    = 1'b1;
        bus.exe_load_i    = load;
        bus.id_rs1_addr_i = rs1;
        bus.id_rs1_re_i   = re1;
        bus.id_rs2_addr_i = rs2;
        bus.id_rs2_re_i   = re2;
    endtask

    // One clock: queue the expectation, compare at the falling edge, advance past the rising edge.
    task automatic cycle(input string tag, input logic [11:0] ectl, input logic [31:0] eaddr);
        sb_tag.push_back(tag);
        sb_ctl.push_back(ectl);
        sb_addr.push_back(eaddr);
        @(negedge clk);
        begin
            string t;
            t = sb_tag.pop_front();
            check({t, "_ctl"}, 64'(got_ctl), 64'(sb_ctl.pop_front()));
            check({t, "_addr"}, 64'(bus.redirect_addr_o), 64'(sb_addr.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        bus.trap_req_i      = 1'b1;
        bus.trap_addr_i     = 32'h100;
        bus.exe_jump_i      = 1'b1;
        bus.exe_jump_addr_i = 32'h80;
        bus.mem_req_i       = 1'b1;
        cycle("rst0", 12'h0, 32'h0);
        cycle("rst1", 12'h0, 32'h0);
        rst = 1'b0;
        clear_in();
        cycle("idle", 12'h0, 32'h0);

        // load-use variants
        set_lu(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1); cycle("lu_rs2", LU, 32'h0);
        clear_in();                                 cycle("lu_rel", 12'h0, 32'h0);
        set_lu(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1); cycle("lu_x0", 12'h0, 32'h0);
        set_lu(5'd7, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1); cycle("lu_rs1", LU, 32'h0);
        set_lu(5'd7, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0); cycle("lu_nore", 12'h0, 32'h0);
        set_lu(5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1); cycle("lu_noload", 12'h0, 32'h0);
        clear_in();

        // 33-cycle mul/div
        bus.exe_md_start_i = 1'b1;
        for (int i = 0; i < 33; i++) cycle("md_wait", MDW, 32'h0);
        bus.md_done_i = 1'b1;       cycle("md_done", 12'h0, 32'h0);
        clear_in();                 cycle("md_after", 12'h0, 32'h0);

        // jump with one extra flush cycle
        bus.exe_jump_i = 1'b1; bus.exe_jump_addr_i = 32'h80;
        cycle("jmp", JMP, 32'h80);
        clear_in();
        cycle("jmp_flush", FLS, 32'h0);
        cycle("jmp_after", 12'h0, 32'h0);

        // trap during mul/div
        bus.exe_md_start_i = 1'b1;  cycle("md_enter", MDW, 32'h0);
        bus.trap_req_i = 1'b1; bus.trap_addr_i = 32'h100;
        cycle("md_trap", TRAP | MDK, 32'h100);
        clear_in();                 cycle("md_trap_fl", FLS, 32'h0);
        cycle("md_trap_end", 12'h0, 32'h0);

        // trap held across a bus wait is only acked back in RUN
        bus.mem_req_i = 1'b1;       cycle("mem_enter", MEMW, 32'h0);
        bus.trap_req_i = 1'b1; bus.trap_addr_i = 32'h200;
        cycle("memw_trap1", MEMW, 32'h0);
        cycle("memw_trap2", MEMW, 32'h0);
        bus.mem_ready_i = 1'b1;     cycle("memw_ready", 12'h0, 32'h0);
        bus.mem_req_i = 1'b0; bus.mem_ready_i = 1'b0;
        cycle("mem_trap_ack", TRAP, 32'h200);
        clear_in();                 cycle("mem_trap_fl", FLS, 32'h0);
        cycle("mem_trap_end", 12'h0, 32'h0);

        // trap beats bus wait in RUN; bus wait then freezes the flush window
        bus.trap_req_i = 1'b1; bus.trap_addr_i = 32'h300; bus.mem_req_i = 1'b1;
        cycle("trap_over_mem", TRAP, 32'h300);
        bus.trap_req_i = 1'b0;
        cycle("fl_memw1", FLS | MEMW, 32'h0);
        cycle("fl_memw2", FLS | MEMW, 32'h0);
        bus.mem_ready_i = 1'b1;     cycle("fl_memready", FLS, 32'h0);
        clear_in();                 cycle("fl_done", 12'h0, 32'h0);

        // trap in RUN kills a starting mul/div and beats a jump
        bus.trap_req_i = 1'b1; bus.trap_addr_i = 32'h400; bus.exe_md_start_i = 1'b1;
        bus.exe_jump_i = 1'b1; bus.exe_jump_addr_i = 32'h80;
        cycle("trap_run_md", TRAP | MDK, 32'h400);
        clear_in();                 cycle("trap_run_fl", FLS, 32'h0);
        cycle("trap_run_end", 12'h0, 32'h0);

        // mul/div finishing in its first cycle costs nothing
        bus.exe_md_start_i = 1'b1; bus.md_done_i = 1'b1;
        cycle("md_fast", 12'h0, 32'h0);
        clear_in();

`ifdef PIPE_CTRL_PERF_EN
        rst = 1'b1;                 cycle("perf_rst", 12'h0, 32'h0);
        rst = 1'b0;
        check("perf_stall0", 64'(stall_cycles), 64'd0);
        check("perf_flush0", 64'(flush_cycles), 64'd0);
        bus.mem_req_i = 1'b1;
        for (int i = 0; i < 5; i++) cycle("perf_memw", MEMW, 32'h0);
        bus.mem_ready_i = 1'b1;     cycle("perf_memrdy", 12'h0, 32'h0);
        clear_in();
        bus.exe_jump_i = 1'b1; bus.exe_jump_addr_i = 32'h80;
        cycle("perf_jmp", JMP, 32'h80);
        clear_in();                 cycle("perf_fl", FLS, 32'h0);
        cycle("perf_idle", 12'h0, 32'h0);
        check("perf_stall", 64'(stall_cycles), 64'd5);
        check("perf_flush", 64'(flush_cycles), 64'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
